regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port between NUM_REQ write-back sources: ALU (index 0), load unit (index 1) and multi-cycle multiplier (index 2).
- Arbitrates round-robin with a valid/ready handshake and registers the winning write onto the RegWrite/WriteRegister/WriteData port.
- Keeps a busy scoreboard of destination registers with outstanding writes; the control unit reads it for hazard stalls.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_wb_arbiter_rr.sv | 51 +++++
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back path.
// Requester indices fix the priority slots of the write-back arbiter.
package regfile_pkg;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 32;
    localparam int NUM_REQ = 3;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_MUL  = 2;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin arbiter with a rotating start pointer.
// Pointer wraps explicitly so non-power-of-two N stays fair.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [N-1:0]  Req,
    input  logic          Accept,
    output logic [N-1:0]  Grant,
    output logic [IW-1:0] GrantIdx
);

    logic [IW-1:0] ptr;
    logic          found;
    int            j;

    // Search from ptr upward, wrapping, and grant the first requester
    always_comb begin
        Grant    = '0;
        GrantIdx = '0;
        found    = 1'b0;
        j        = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && Req[j]) begin
                found    = 1'b1;
                Grant[j] = 1'b1;
                GrantIdx = IW'(j);
            end
        end
    end

    // Move the pointer just past the winner on every accepted grant
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ptr <= '0;
        end else if (Accept) begin
            if (GrantIdx == IW'(N - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= GrantIdx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single register-file write port.
// Registers the winning write and tracks outstanding destinations.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = regfile_pkg::NUM_REQ,
    parameter int DATA_W  = regfile_pkg::DATA_W,
    parameter int ADDR_W  = regfile_pkg::ADDR_W
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NUM_REQ-1:0]        ReqValid,
    input  logic [NUM_REQ*ADDR_W-1:0] ReqAddr,
    input  logic [NUM_REQ*DATA_W-1:0] ReqData,
    output logic [NUM_REQ-1:0]        ReqReady,
    input  logic                      IssueValid,
    input  logic [ADDR_W-1:0]         IssueAddr,
    output logic                      RegWrite,
    output logic [ADDR_W-1:0]         WriteRegister,
    output logic [DATA_W-1:0]         WriteData,
    output logic [2**ADDR_W-1:0]      BusyVec
);

    localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NREG = 2**ADDR_W;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      gidx;
    logic               accept;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               reg_write;
    logic [ADDR_W-1:0]  write_register;
    logic [DATA_W-1:0]  write_data;
    logic [NREG-1:0]    busy;
    logic [NREG-1:0]    busy_nxt;

    // Requests are masked while reset is held so no grant can leak out
    assign req      = Rst ? ReqValid : '0;
    assign accept   = |grant;
    assign ReqReady = grant;

    assign sel_addr = ReqAddr[int'(gidx)*ADDR_W +: ADDR_W];
    assign sel_data = ReqData[int'(gidx)*DATA_W +: DATA_W];

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .Clk      (Clk),
        .Rst      (Rst),
        .Req      (req),
        .Accept   (accept),
        .Grant    (grant),
        .GrantIdx (gidx)
    );

    // Register the accepted write; address 0 is accepted but never written
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            reg_write      <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
        end else begin
            reg_write <= accept && (sel_addr != '0);
            if (accept) begin
                write_register <= sel_addr;
                write_data     <= sel_data;
            end
        end
    end

    // Clear on completing write, then set on issue so a new issue wins
    always_comb begin
        busy_nxt = busy;
        if (reg_write) begin
            busy_nxt[write_register] = 1'b0;
        end
        if (IssueValid && (IssueAddr != '0)) begin
            busy_nxt[IssueAddr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard state
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign RegWrite      = reg_write;
    assign WriteRegister = write_register;
    assign WriteData     = write_data;
    assign BusyVec       = busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for the write-back arbiter and busy scoreboard.
// Each task drives one scenario and compares against hand-computed values.
module tb_regfile_wb_arbiter;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [2:0]  ReqValid = '0;
    logic [11:0] ReqAddr = '0;
    logic [95:0] ReqData = '0;
    logic [2:0]  ReqReady;
    logic        IssueValid = 1'b0;
    logic [3:0]  IssueAddr = '0;
    logic        RegWrite;
    logic [3:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [15:0] BusyVec;

    int vecs = 0;
    int errs = 0;

    regfile_wb_arbiter dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .ReqValid      (ReqValid),
        .ReqAddr       (ReqAddr),
        .ReqData       (ReqData),
        .ReqReady      (ReqReady),
        .IssueValid    (IssueValid),
        .IssueAddr     (IssueAddr),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .BusyVec       (BusyVec)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v,
                           input logic [3:0] a, input logic [31:0] d);
        ReqValid[i]         = v;
        ReqAddr[i*4 +: 4]   = a;
        ReqData[i*32 +: 32] = d;
    endtask

    task automatic test_reset();
        Rst        = 1'b0;
        ReqValid   = 3'b111;
        IssueValid = 1'b1;
        IssueAddr  = 4'd4;
        tick();
        tick();
        vecs++;
        if (ReqReady !== 3'b000) begin
            errs++;
            $display("FAIL reset_ready: got %b want %b", ReqReady, 3'b000);
        end
        vecs++;
        if (RegWrite !== 1'b0) begin
            errs++;
            $display("FAIL reset_regwrite: got %b want 0", RegWrite);
        end
        vecs++;
        if (WriteRegister !== 4'd0 || WriteData !== 32'd0) begin
            errs++;
            $display("FAIL reset_port: got %h/%h want 0/0",
                     WriteRegister, WriteData);
        end
        vecs++;
        if (BusyVec !== 16'h0000) begin
            errs++;
            $display("FAIL reset_busy: got %h want 0000", BusyVec);
        end
        ReqValid   = 3'b000;
        IssueValid = 1'b0;
        Rst        = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_req(0, 1'b1, 4'd3, 32'h12345678);
        #1;
        vecs++;
        if (ReqReady !== 3'b001) begin
            errs++;
            $display("FAIL single_ready: got %b want 001", ReqReady);
        end
        tick();
        vecs++;
        if (RegWrite !== 1'b1 || WriteRegister !== 4'd3 ||
            WriteData !== 32'h12345678) begin
            errs++;
            $display("FAIL single_write: got %b/%h/%h want 1/3/12345678",
                     RegWrite, WriteRegister, WriteData);
        end
        set_req(0, 1'b0, 4'd0, 32'd0);
        #1;
        vecs++;
        if (ReqReady !== 3'b000) begin
            errs++;
            $display("FAIL idle_ready: got %b want 000", ReqReady);
        end
        tick();
        vecs++;
        if (RegWrite !== 1'b0 || WriteRegister !== 4'd3 ||
            WriteData !== 32'h12345678) begin
            errs++;
            $display("FAIL idle_hold: got %b/%h/%h want 0/3/12345678",
                     RegWrite, WriteRegister, WriteData);
        end
    endtask

    task automatic test_reset_midstream();
        set_req(0, 1'b1, 4'd5, 32'hDEADBEEF);
        #1;
        vecs++;
        if (ReqReady !== 3'b001) begin
            errs++;
            $display("FAIL mid_ready: got %b want 001", ReqReady);
        end
        tick();
        vecs++;
        if (RegWrite !== 1'b1 || WriteData !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL mid_pending: got %b/%h want 1/deadbeef",
                     RegWrite, WriteData);
        end
        Rst = 1'b0;
        #1;
        vecs++;
        if (RegWrite !== 1'b0 || WriteData !== 32'd0 ||
            WriteRegister !== 4'd0) begin
            errs++;
            $display("FAIL mid_discard: got %b/%h/%h want 0/0/0",
                     RegWrite, WriteRegister, WriteData);
        end
        vecs++;
        if (ReqReady !== 3'b000) begin
            errs++;
            $display("FAIL mid_mask: got %b want 000", ReqReady);
        end
        IssueValid = 1'b1;
        IssueAddr  = 4'd5;
        tick();
        vecs++;
        if (BusyVec !== 16'h0000) begin
            errs++;
            $display("FAIL mid_busy: got %h want 0000", BusyVec);
        end
        IssueValid = 1'b0;
        set_req(0, 1'b0, 4'd0, 32'd0);
        Rst = 1'b1;
        ReqValid = 3'b111;
        #1;
        vecs++;
        if (ReqReady !== 3'b001) begin
            errs++;
            $display("FAIL mid_ptr: got %b want 001", ReqReady);
        end
        ReqValid = 3'b000;
        tick();
    endtask

    task automatic test_fairness();
        logic [2:0]  exp_g [3];
        logic [3:0]  exp_a [3];
        logic [31:0] exp_d [3];
        exp_g[0] = 3'b001; exp_a[0] = 4'd1; exp_d[0] = 32'hA0A00001;
        exp_g[1] = 3'b010; exp_a[1] = 4'd2; exp_d[1] = 32'hB1B10002;
        exp_g[2] = 3'b100; exp_a[2] = 4'd4; exp_d[2] = 32'hC2C20004;
        for (int i = 0; i < 3; i++) begin
            set_req(i, 1'b1, exp_a[i], exp_d[i]);
        end
        for (int k = 0; k < 6; k++) begin
            #1;
            vecs++;
            if (ReqReady !== exp_g[k % 3]) begin
                errs++;
                $display("FAIL fair_grant[%0d]: got %b want %b",
                         k, ReqReady, exp_g[k % 3]);
            end
            tick();
            vecs++;
            if (RegWrite !== 1'b1 || WriteRegister !== exp_a[k % 3] ||
                WriteData !== exp_d[k % 3]) begin
                errs++;
                $display("FAIL fair_write[%0d]: got %b/%h/%h want 1/%h/%h",
                         k, RegWrite, WriteRegister, WriteData,
                         exp_a[k % 3], exp_d[k % 3]);
            end
        end
        ReqValid = 3'b000;
    endtask

    task automatic test_addr0();
        set_req(1, 1'b1, 4'd0, 32'hFFFFFFFF);
        #1;
        vecs++;
        if (ReqReady !== 3'b010) begin
            errs++;
            $display("FAIL a0_ready: got %b want 010", ReqReady);
        end
        tick();
        vecs++;
        if (RegWrite !== 1'b0) begin
            errs++;
            $display("FAIL a0_regwrite: got %b want 0", RegWrite);
        end
        set_req(0, 1'b1, 4'd6, 32'h66666666);
        set_req(1, 1'b1, 4'd8, 32'h88888888);
        set_req(2, 1'b1, 4'd10, 32'h55555555);
        #1;
        vecs++;
        if (ReqReady !== 3'b100) begin
            errs++;
            $display("FAIL a0_next: got %b want 100", ReqReady);
        end
        tick();
        vecs++;
        if (RegWrite !== 1'b1 || WriteRegister !== 4'd10 ||
            WriteData !== 32'h55555555) begin
            errs++;
            $display("FAIL a0_mul: got %b/%h/%h want 1/a/55555555",
                     RegWrite, WriteRegister, WriteData);
        end
        ReqValid = 3'b000;
    endtask

    task automatic test_scoreboard();
        IssueValid = 1'b1;
        IssueAddr  = 4'd7;
        tick();
        IssueValid = 1'b0;
        vecs++;
        if (BusyVec !== 16'h0080) begin
            errs++;
            $display("FAIL sb_set: got %h want 0080", BusyVec);
        end
        set_req(2, 1'b1, 4'd7, 32'h77777777);
        #1;
        vecs++;
        if (ReqReady !== 3'b100) begin
            errs++;
            $display("FAIL sb_ready: got %b want 100", ReqReady);
        end
        tick();
        set_req(2, 1'b0, 4'd0, 32'd0);
        vecs++;
        if (RegWrite !== 1'b1 || WriteRegister !== 4'd7 ||
            BusyVec !== 16'h0080) begin
            errs++;
            $display("FAIL sb_write: got %b/%h/%h want 1/7/0080",
                     RegWrite, WriteRegister, BusyVec);
        end
        tick();
        vecs++;
        if (BusyVec !== 16'h0000) begin
            errs++;
            $display("FAIL sb_clear: got %h want 0000", BusyVec);
        end
        IssueValid = 1'b1;
        IssueAddr  = 4'd7;
        tick();
        IssueValid = 1'b0;
        set_req(2, 1'b1, 4'd7, 32'h70707070);
        tick();
        set_req(2, 1'b0, 4'd0, 32'd0);
        vecs++;
        if (RegWrite !== 1'b1 || WriteRegister !== 4'd7) begin
            errs++;
            $display("FAIL sb_rewrite: got %b/%h want 1/7",
                     RegWrite, WriteRegister);
        end
        IssueValid = 1'b1;
        IssueAddr  = 4'd7;
        tick();
        IssueValid = 1'b0;
        vecs++;
        if (BusyVec !== 16'h0080) begin
            errs++;
            $display("FAIL sb_setwins: got %h want 0080", BusyVec);
        end
        tick();
        vecs++;
        if (BusyVec !== 16'h0080) begin
            errs++;
            $display("FAIL sb_stays: got %h want 0080", BusyVec);
        end
    endtask

    task automatic test_held();
        int gcyc;
        gcyc = -1;
        set_req(0, 1'b1, 4'd7, 32'h11110007);
        set_req(1, 1'b1, 4'd2, 32'h22220002);
        set_req(2, 1'b1, 4'd9, 32'h99990009);
        for (int c = 0; c < 3 && gcyc < 0; c++) begin
            #1;
            if (ReqReady[2]) begin
                gcyc = c;
            end
            tick();
        end
        ReqValid = 3'b000;
        vecs++;
        if (gcyc != 2) begin
            errs++;
            $display("FAIL held_grant_cycle: got %0d want 2", gcyc);
        end
        vecs++;
        if (RegWrite !== 1'b1 || WriteRegister !== 4'd9 ||
            WriteData !== 32'h99990009) begin
            errs++;
            $display("FAIL held_write: got %b/%h/%h want 1/9/99990009",
                     RegWrite, WriteRegister, WriteData);
        end
        IssueValid = 1'b1;
        IssueAddr  = 4'd0;
        tick();
        IssueValid = 1'b0;
        vecs++;
        if (BusyVec !== 16'h0000) begin
            errs++;
            $display("FAIL held_busy0: got %h want 0000", BusyVec);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_midstream();
        test_fairness();
        test_addr0();
        test_scoreboard();
        test_held();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
